seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-digit seven-segment display.
- Sits directly upstream of the hex-to-segment decoder. It holds a 32-bit display word plus per-digit point and blank masks, and selects one digit at a time.
- Drives that digit's nibble to the decoder and the matching active-low anode, with inter-digit ghost blanking.
- New data is double-buffered and committed only at frame boundaries, so the display never shows a torn word.

Parameters:
- CLK_DIV, 50000: clk cycles per digit slot; legal range 2..2^20.
- BLANK_CYC, 16: cycles at the start of each slot during which all anodes are off; must satisfy 0 <= BLANK_CYC < CLK_DIV.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  scan enable; low = display dark
- wr_en  in  1  single-cycle write strobe for the shadow registers
- wr_data  in  32  display word; digit k = wr_data[4k+3:4k]
- wr_dp  in  8  decimal-point mask; bit k lights the point of digit k
- wr_blank  in  8  blank mask; bit k forces digit k dark
- hex  out  4  nibble of the current digit, to the decoder
- dp_n  out  1  active-low decimal point of the current digit
- anode_n  out  8  active-low digit select; at most one bit low
- seg_off  out  1  high = downstream must drive all segments off
- frame_start  out  1  one-cycle pulse when digit 0's slot begins
- pending  out  1  shadow holds data not yet committed

Behaviour:
- Reset (async, rst_n low): anode_n=8'hFF, hex=0, dp_n=1, seg_off=1, frame_start=0, pending=0. Active and shadow registers = 0. Slot counter cnt=0, digit index idx=0.
- Counter: cnt counts 0..CLK_DIV-1 and wraps to 0. On wrap, idx advances 0,1,...,7 and then back to 0.
- Boundary cycle: the cycle with idx==7 and cnt==CLK_DIV-1.
- Shadow write: wr_en loads shadow_data/dp/blank and sets pending. Multiple writes before a boundary: the last one wins.
- Commit: on a boundary cycle with pending=1, shadow is copied to active and pending clears.
- Write on the boundary cycle itself: wr_data/wr_dp/wr_blank load directly into both shadow and active; pending stays 0.
- Output decode uses the current idx and cnt. All outputs are registered, one cycle after the state that produces them.
  - cnt < BLANK_CYC, or active_blank[idx]=1: anode_n=8'hFF, seg_off=1, dp_n=1.
  - Otherwise: anode_n = ~(8'b1 << idx), seg_off=0, dp_n = ~active_dp[idx].
  - hex = active_data[4*idx+3 : 4*idx] at all times, including blanking.
- frame_start: asserted for one cycle on the output registered from the state idx==0, cnt==0. Suppressed while en=0.
- en=0 behaviour:
  - cnt and idx are held at 0; anode_n=8'hFF, seg_off=1, dp_n=1.
  - A pending shadow commits immediately, in the next cycle.
  - wr_en on its own writes shadow, sets pending and commits the next cycle.
  - wr_en together with the commit cycle loads directly into active.
- en rising: the scan starts at idx=0, cnt=0. frame_start appears on the first output cycle.
- Reset mid-frame: everything returns to reset values at once; no partial commit survives.
- Width rule: cnt is the minimal width for CLK_DIV-1; idx is 3 bits and wraps naturally modulo 8.

Decomposition:
- Package seg_pkg holds:
  - N_DIG=8
  - ANODE_OFF=8'hFF
  - the function for cnt width (clog2)
  - a typedef for the 4-bit nibble
- One sub-module, seg_scan_timer, holds cnt and idx. It generates the boundary, slot_start and blank_window strobes, with inputs clk, rst_n, en.
- The top level holds the shadow/active registers, the commit logic and the output registers.

Test Plan (CLK_DIV=4, BLANK_CYC=1):
1. Reset then en=1, write wr_data=32'h76543210, wr_dp=8'h01, wr_blank=0 -> after the first boundary, each 4-cycle slot shows 1 cycle with anode_n=FF/seg_off=1, then 3 cycles with anode_n=~(1<<k), hex=k. dp_n=0 only for digit 0; frame_start pulses every 32 cycles.
2. Write 32'hAAAAAAAA mid-frame at idx=3 -> pending=1; digits 3..7 still show the old word; from the next frame on hex=A for every digit and pending=0.
3. Write on the exact boundary cycle with 32'h12345678 -> next frame shows digit0=8, digit7=1, and pending is never set.
4. wr_blank=8'h80 -> digit 7's slot keeps anode_n=FF and seg_off=1 for all 4 cycles; the other digits are unaffected.
5. en dropped at idx=5 -> next cycle anode_n=FF; write 32'hFFFF0000 while en=0 -> pending clears 1 cycle later; en high -> digit 0 is first, hex=0, with frame_start.
6. rst_n asserted mid-slot with pending=1 -> outputs take reset values asynchronously; after release with en=1, hex=0 for all digits and pending=0.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seg_pkg;

  localparam int unsigned N_DIG  = 8;
  localparam int unsigned IDX_W  = $clog2(N_DIG);
  localparam int unsigned WORD_W = 4 * N_DIG;

  localparam logic [N_DIG-1:0] ANODE_OFF = 8'hFF;

  typedef logic [3:0] nibble_t;

  // Minimal counter width able to hold div-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Write port and display outputs of the scan controller, bundled as one interface.
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic                en;
  logic                wr_en;
  logic [WORD_W-1:0]   wr_data;
  logic [N_DIG-1:0]    wr_dp;
  logic [N_DIG-1:0]    wr_blank;

  nibble_t             hex;
  logic                dp_n;
  logic [N_DIG-1:0]    anode_n;
  logic                seg_off;
  logic                frame_start;
  logic                pending;

  modport master (
    output en, wr_en, wr_data, wr_dp, wr_blank,
    input  hex, dp_n, anode_n, seg_off, frame_start, pending
  );

  modport slave (
    input  en, wr_en, wr_data, wr_dp, wr_blank,
    output hex, dp_n, anode_n, seg_off, frame_start, pending
  );

endinterface

// File: rtl/seg_scan_ctrl_timer.sv
// Slot counter and digit index for the scan; derives boundary, slot-start
// and ghost-blanking strobes from the current count.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             boundary_c_o,
  output logic             slot_start_c_o,
  output logic             blank_window_c_o
);

  localparam int unsigned      CNT_W    = cnt_width(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIG - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Disabled scan parks at digit 0, count 0; idx wraps modulo N_DIG.
  always_comb begin : next_comb
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!en_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_ff
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o          = idx_q;
  assign boundary_c_o   = en_i && (idx_q == LAST_IDX) && (cnt_q == CNT_MAX);
  assign slot_start_c_o = (cnt_q == '0);

  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign blank_window_c_o = 1'b0;
    end else begin : g_blank
      assign blank_window_c_o = (cnt_q < CNT_W'(BLANK_CYC));
    end
  endgenerate

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: double-buffered display word,
// frame-aligned commit, and registered per-digit drive toward the decoder.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  seg_scan_ctrl_if.slave  bus
);

  logic [IDX_W-1:0]  idx;
  logic              boundary_c;
  logic              slot_start_c;
  logic              blank_window_c;
  logic              commit_slot_c;
  logic              dark_c;

  logic [WORD_W-1:0] shadow_data_q, shadow_data_d;
  logic [N_DIG-1:0]  shadow_dp_q, shadow_dp_d;
  logic [N_DIG-1:0]  shadow_blank_q, shadow_blank_d;
  logic [WORD_W-1:0] active_data_q, active_data_d;
  logic [N_DIG-1:0]  active_dp_q, active_dp_d;
  logic [N_DIG-1:0]  active_blank_q, active_blank_d;
  logic              pending_q, pending_d;

  nibble_t           hex_q, hex_d;
  logic              dp_n_q, dp_n_d;
  logic [N_DIG-1:0]  anode_n_q, anode_n_d;
  logic              seg_off_q, seg_off_d;
  logic              frame_start_q, frame_start_d;

  seg_scan_timer #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk              (clk),
    .rst_n            (rst_n),
    .en_i             (bus.en),
    .idx_o            (idx),
    .boundary_c_o     (boundary_c),
    .slot_start_c_o   (slot_start_c),
    .blank_window_c_o (blank_window_c)
  );

  // A commit may happen at the frame boundary, or at once while the scan is idle.
  assign commit_slot_c = boundary_c || (!bus.en && pending_q);

  always_comb begin : commit_comb
    shadow_data_d  = shadow_data_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    active_data_d  = active_data_q;
    active_dp_d    = active_dp_q;
    active_blank_d = active_blank_q;
    pending_d      = pending_q;
    if (bus.wr_en) begin
      shadow_data_d  = bus.wr_data;
      shadow_dp_d    = bus.wr_dp;
      shadow_blank_d = bus.wr_blank;
      if (commit_slot_c) begin
        active_data_d  = bus.wr_data;
        active_dp_d    = bus.wr_dp;
        active_blank_d = bus.wr_blank;
        pending_d      = 1'b0;
      end else begin
        pending_d      = 1'b1;
      end
    end else if (commit_slot_c && pending_q) begin
      active_data_d  = shadow_data_q;
      active_dp_d    = shadow_dp_q;
      active_blank_d = shadow_blank_q;
      pending_d      = 1'b0;
    end
  end

  assign dark_c = !bus.en || blank_window_c || active_blank_q[idx];

  // Digit drive decoded from the current slot; the nibble follows idx even while dark.
  always_comb begin : out_comb
    hex_d         = active_data_q[{idx, 2'b00} +: 4];
    seg_off_d     = dark_c;
    anode_n_d     = ANODE_OFF;
    dp_n_d        = 1'b1;
    frame_start_d = bus.en && slot_start_c && (idx == '0);
    if (!dark_c) begin
      anode_n_d = ~(N_DIG'(1) << idx);
      dp_n_d    = ~active_dp_q[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : reg_ff
    if (!rst_n) begin
      shadow_data_q  <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      active_data_q  <= '0;
      active_dp_q    <= '0;
      active_blank_q <= '0;
      pending_q      <= 1'b0;
      hex_q          <= '0;
      dp_n_q         <= 1'b1;
      anode_n_q      <= ANODE_OFF;
      seg_off_q      <= 1'b1;
      frame_start_q  <= 1'b0;
    end else begin
      shadow_data_q  <= shadow_data_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      active_data_q  <= active_data_d;
      active_dp_q    <= active_dp_d;
      active_blank_q <= active_blank_d;
      pending_q      <= pending_d;
      hex_q          <= hex_d;
      dp_n_q         <= dp_n_d;
      anode_n_q      <= anode_n_d;
      seg_off_q      <= seg_off_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign bus.hex         = hex_q;
  assign bus.dp_n        = dp_n_q;
  assign bus.anode_n     = anode_n_q;
  assign bus.seg_off     = seg_off_q;
  assign bus.frame_start = frame_start_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with CLK_DIV=4, BLANK_CYC=1: expected
// per-cycle outputs are queued ahead of time and a monitor compares them.
module tb_seg_scan_ctrl;

  localparam int unsigned TB_DIV = 4;
  localparam int unsigned TB_BLK = 1;

  typedef struct {
    int         cyc;
    logic [7:0] anode;
    logic [3:0] hex;
    logic       dp_n;
    logic       seg_off;
    logic       fs;
    logic       pend;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  seg_scan_ctrl_if bus_if();

  seg_scan_ctrl #(
    .CLK_DIV   (TB_DIV),
    .BLANK_CYC (TB_BLK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected scan output for relative cycles j0..j1 after the enable edge 'base'.
  task automatic push_scan(input int base, input int j0, input int j1,
                           input logic [31:0] d, input logic [7:0] dp,
                           input logic [7:0] bl, input int p_lo, input int p_hi);
    exp_t e;
    for (int j = j0; j <= j1; j++) begin
      int  k;
      int  c;
      bit  dark;
      k    = (j / int'(TB_DIV)) % 8;
      c    = j % int'(TB_DIV);
      dark = (c < int'(TB_BLK)) || bl[k];
      e.cyc     = base + j;
      e.hex     = d[4*k +: 4];
      e.anode   = dark ? 8'hFF : ~(8'd1 << k);
      e.seg_off = dark;
      e.dp_n    = dark ? 1'b1 : ~dp[k];
      e.fs      = ((j % (8 * int'(TB_DIV))) == 0);
      e.pend    = (j >= p_lo) && (j <= p_hi);
      q.push_back(e);
    end
  endtask

  // Expected dark output (reset or disabled) for absolute cycles c0..c1.
  task automatic push_dark(input int c0, input int c1, input logic [3:0] h, input logic p);
    exp_t e;
    for (int c = c0; c <= c1; c++) begin
      e.cyc = c; e.hex = h; e.anode = 8'hFF; e.seg_off = 1'b1;
      e.dp_n = 1'b1; e.fs = 1'b0; e.pend = p;
      q.push_back(e);
    end
  endtask

  // Return 1 time unit after clock edge n; inputs set here are sampled at edge n+1.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input int edge_n, input logic [31:0] d,
                          input logic [7:0] dp, input logic [7:0] bl);
    goto(edge_n - 1);
    bus_if.wr_en    = 1'b1;
    bus_if.wr_data  = d;
    bus_if.wr_dp    = dp;
    bus_if.wr_blank = bl;
    goto(edge_n);
    bus_if.wr_en    = 1'b0;
  endtask

  // Monitor: one comparison per queued expectation, at the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc != cyc || bus_if.anode_n !== e.anode || bus_if.hex !== e.hex ||
            bus_if.dp_n !== e.dp_n || bus_if.seg_off !== e.seg_off ||
            bus_if.frame_start !== e.fs || bus_if.pending !== e.pend) begin
          errors++;
          $display("FAIL cyc%0d (now %0d): got anode_n=%h hex=%h dp_n=%b seg_off=%b frame_start=%b pending=%b, want anode_n=%h hex=%h dp_n=%b seg_off=%b frame_start=%b pending=%b",
                   e.cyc, cyc, bus_if.anode_n, bus_if.hex, bus_if.dp_n, bus_if.seg_off,
                   bus_if.frame_start, bus_if.pending, e.anode, e.hex, e.dp_n,
                   e.seg_off, e.fs, e.pend);
        end
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int e1;
    int e2;
    int e3;
    bus_if.en       = 1'b0;
    bus_if.wr_en    = 1'b0;
    bus_if.wr_data  = '0;
    bus_if.wr_dp    = '0;
    bus_if.wr_blank = '0;

    // Reset, then idle with the scan disabled.
    push_dark(1, 5, 4'h0, 1'b0);
    e1 = 6;
    push_scan(e1,   0,  31, 32'h00000000, 8'h00, 8'h00,   0,  30);
    push_scan(e1,  32,  63, 32'h76543210, 8'h01, 8'h00,  -1,  -1);
    push_scan(e1,  64,  95, 32'h76543210, 8'h01, 8'h00,  77,  94);
    push_scan(e1,  96, 127, 32'hAAAAAAAA, 8'h00, 8'h00,  -1,  -1);
    push_scan(e1, 128, 159, 32'h12345678, 8'h00, 8'h00, 140, 158);
    push_scan(e1, 160, 191, 32'h12345678, 8'h00, 8'h80,  -1,  -1);
    push_scan(e1, 192, 212, 32'h12345678, 8'h00, 8'h80,  -1,  -1);
    goto(3);
    rst_n = 1'b1;

    goto(e1 - 1);
    bus_if.en = 1'b1;
    do_write(e1, 32'h76543210, 8'h01, 8'h00);
    do_write(e1 + 77,  32'hAAAAAAAA, 8'h00, 8'h00);
    do_write(e1 + 127, 32'h12345678, 8'h00, 8'h00);
    do_write(e1 + 140, 32'h12345678, 8'h00, 8'h80);

    // Drop enable during digit 5, write while idle.
    goto(e1 + 212);
    push_dark(e1 + 213, e1 + 213, 4'h3, 1'b0);
    push_dark(e1 + 214, e1 + 214, 4'h8, 1'b0);
    push_dark(e1 + 215, e1 + 215, 4'h8, 1'b1);
    push_dark(e1 + 216, e1 + 216, 4'h8, 1'b0);
    push_dark(e1 + 217, e1 + 219, 4'h0, 1'b0);
    bus_if.en = 1'b0;
    do_write(e1 + 215, 32'hFFFF0000, 8'h00, 8'h00);

    // Re-enable: scan restarts at digit 0 with the committed word.
    e2 = e1 + 220;
    goto(e2 - 1);
    push_scan(e2, 0, 41, 32'hFFFF0000, 8'h00, 8'h00, 40, 41);
    bus_if.en = 1'b1;
    do_write(e2 + 40, 32'h55555555, 8'hFF, 8'h00);

    // Asynchronous reset mid-slot with a pending write.
    goto(e2 + 42);
    e3 = e2 + 46;
    push_dark(e2 + 42, e2 + 45, 4'h0, 1'b0);
    push_scan(e3, 0, 63, 32'h00000000, 8'h00, 8'h00, -1, -1);
    #1;
    rst_n = 1'b0;
    goto(e3 - 1);
    rst_n = 1'b1;

    goto(e3 + 68);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
